// File: rtl/encrypt_pkg.sv
// Shared types, ASCII limits and Caesar helpers for the encrypt/decrypt byte pipelines.
package encrypt_pkg;

  typedef logic [7:0]      byte_t;
  typedef logic [7:0][2:0] perm_map_t;
  typedef enum logic [1:0] {K1 = 2'd0, K2 = 2'd1, K3 = 2'd2} key_sel_e;

  localparam byte_t ASCII_UP_A = 8'h41;
  localparam byte_t ASCII_UP_Z = 8'h5A;
  localparam byte_t ASCII_LO_A = 8'h61;
  localparam byte_t ASCII_LO_Z = 8'h7A;
  localparam byte_t ALPHA_LEN  = 8'd26;
  localparam int    PIPE_LAT   = 4;

  function automatic logic is_upper(input byte_t c);
    return (c >= ASCII_UP_A) && (c <= ASCII_UP_Z);
  endfunction

  function automatic logic is_lower(input byte_t c);
    return (c >= ASCII_LO_A) && (c <= ASCII_LO_Z);
  endfunction

  // Offset within the alphabet never exceeds 25+7, so one conditional subtract wraps it.
  function automatic byte_t caesar_fwd(input byte_t c, input byte_t base, input logic [2:0] amt);
    byte_t ofs;
    ofs = c - base + {5'b0, amt};
    if (ofs >= ALPHA_LEN) ofs = ofs - ALPHA_LEN;
    return ofs + base;
  endfunction

endpackage

// File: rtl/encrypt_pipe_xor.sv
// Final stage: rotating-key XOR plus the key-rotation counter/selector FSM.
// Optional ENCRYPT_PIPE_PARITY_EN adds a registered even-parity output.
module encrypt_pipe_xor
  import encrypt_pkg::*;
#(
  parameter int ROT_CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_v,
  input  logic [7:0] i_data,
  input  logic [7:0] i_k1,
  input  logic [7:0] i_k2,
  input  logic [7:0] i_k3,
  input  logic [2:0] i_rot_freq,
  input  logic       i_mode,
  output logic       o_v,
`ifdef ENCRYPT_PIPE_PARITY_EN
  output logic       o_par,
`endif
  output logic [7:0] o_data
);

  key_sel_e               r_key_sel;
  key_sel_e               w_key_sel_next;
  logic [ROT_CNT_W-1:0]   r_rot_cnt;
  logic [ROT_CNT_W-1:0]   w_rot_cnt_next;
  logic [ROT_CNT_W-1:0]   w_freq;
  logic [7:0]             w_key;
  logic [7:0]             w_out;
  logic                   r_v;
  logic [7:0]             r_data;

  assign w_freq = ROT_CNT_W'(i_rot_freq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_sel <= K1;
      r_rot_cnt <= '0;
    end else begin
      r_key_sel <= w_key_sel_next;
      r_rot_cnt <= w_rot_cnt_next;
    end
  end

  always_comb begin
    w_key_sel_next = r_key_sel;
    w_rot_cnt_next = r_rot_cnt;
    case (r_key_sel)
      K1, K2, K3: ;
      default:    w_key_sel_next = K1;
    endcase
    // Rotation state is frozen in bypass and when rotation is disabled.
    if (i_v && i_mode && (i_rot_freq != 3'd0)) begin
      if (r_rot_cnt == w_freq - ROT_CNT_W'(1)) begin
        w_rot_cnt_next = '0;
        case (r_key_sel)
          K1:      w_key_sel_next = K2;
          K2:      w_key_sel_next = K3;
          default: w_key_sel_next = K1;
        endcase
      end else begin
        w_rot_cnt_next = r_rot_cnt + ROT_CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (r_key_sel)
      K2:      w_key = i_k2;
      K3:      w_key = i_k3;
      default: w_key = i_k1;
    endcase
    w_out = i_mode ? (i_data ^ w_key) : i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_data <= '0;
    end else begin
      r_v    <= i_v;
      r_data <= i_v ? w_out : 8'h00;
    end
  end

`ifdef ENCRYPT_PIPE_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par <= 1'b0;
    else        r_par <= i_v ? ^w_out : 1'b0;
  end

  assign o_par = r_par;
`endif

  assign o_v    = r_v;
  assign o_data = r_data;

endmodule

// File: rtl/encrypt_pipe.sv
// Four-stage byte encryptor: classify -> Caesar shift -> bit scatter -> rotating-key XOR.
// Define ENCRYPT_PIPE_PARITY_EN to add the dout_par output.
module encrypt_pipe #(
  parameter int ROT_CNT_W = 3,
  parameter int PIPE_LAT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  input  logic       shift_en,
  input  logic [2:0] shift_amt,
  input  logic       mode,
  input  logic [2:0] perm0,
  input  logic [2:0] perm1,
  input  logic [2:0] perm2,
  input  logic [2:0] perm3,
  input  logic [2:0] perm4,
  input  logic [2:0] perm5,
  input  logic [2:0] perm6,
  input  logic [2:0] perm7,
  output logic       v,
`ifdef ENCRYPT_PIPE_PARITY_EN
  output logic       dout_par,
`endif
  output logic [7:0] dout
);
  import encrypt_pkg::*;

  perm_map_t           w_perm;
  logic [PIPE_LAT-2:0] r_vld;
  byte_t               r_s1_data;
  logic                r_s1_up;
  logic                r_s1_lo;
  byte_t               r_s2_data;
  byte_t               r_s3_data;
  byte_t               w_s2_next;
  byte_t               w_s3_next;

  assign w_perm = {perm7, perm6, perm5, perm4, perm3, perm2, perm1, perm0};

  // r_vld[0] tags S1, r_vld[PIPE_LAT-2] tags S3; S4 holds its own valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vld <= '0;
    else      r_vld <= {r_vld[PIPE_LAT-3:0], en};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_data <= '0;
      r_s1_up   <= 1'b0;
      r_s1_lo   <= 1'b0;
    end else begin
      r_s1_data <= din;
      r_s1_up   <= is_upper(din);
      r_s1_lo   <= is_lower(din);
    end
  end

  always_comb begin
    w_s2_next = r_s1_data;
    if (mode && shift_en) begin
      if (r_s1_up)      w_s2_next = caesar_fwd(r_s1_data, ASCII_UP_A, shift_amt);
      else if (r_s1_lo) w_s2_next = caesar_fwd(r_s1_data, ASCII_LO_A, shift_amt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_s2_data <= '0;
    else      r_s2_data <= w_s2_next;
  end

  // Later source bits overwrite earlier ones, so the higher index wins a collision.
  always_comb begin
    w_s3_next = '0;
    if (mode) begin
      for (int n = 0; n < 8; n++) w_s3_next[w_perm[n]] = r_s2_data[n];
    end else begin
      w_s3_next = r_s2_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_s3_data <= '0;
    else      r_s3_data <= w_s3_next;
  end

  encrypt_pipe_xor #(
    .ROT_CNT_W (ROT_CNT_W)
  ) u_xor (
    .clk        (clk),
    .rst_n      (rst),
    .i_v        (r_vld[PIPE_LAT-2]),
    .i_data     (r_s3_data),
    .i_k1       (k1),
    .i_k2       (k2),
    .i_k3       (k3),
    .i_rot_freq (rot_freq),
    .i_mode     (mode),
    .o_v        (v),
`ifdef ENCRYPT_PIPE_PARITY_EN
    .o_par      (dout_par),
`endif
    .o_data     (dout)
  );

endmodule
